trisc_fetch_sequencer: RTL and testbench

- Instruction-supply end of the TRISC control path.
- Holds the program counter (PC), fetches 8-bit instruction words from program memory over a req/ack handshake, and latches them into an instruction register.
- Presents opcode[7:4] and operand[3:0] to the control unit, then waits for that unit to report completion and whether a jump was taken.
- Handles the halt opcode, illegal opcodes and restart.

---
 rtl/trisc_fetch_sequencer_if.sv | 26 ++
 rtl/trisc_fetch_sequencer.sv | 83 ++++++++
 tb/tb_trisc_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/trisc_fetch_sequencer_if.sv
// Sequencer-side bundle: program-memory read port plus the control-unit
// instruction handshake. The master modport is the sequencer's view.
interface trisc_fetch_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              MemReq;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemData;
  logic              MemAck;
  logic [3:0]        Opcode;
  logic [ADDR_W-1:0] Operand;
  logic              InstrValid;
  logic              InstrDone;
  logic              TakeJump;

  modport master (
    output MemReq, MemAddr, Opcode, Operand, InstrValid,
    input  MemData, MemAck, InstrDone, TakeJump
  );

  modport slave (
    input  MemReq, MemAddr, Opcode, Operand, InstrValid,
    output MemData, MemAck, InstrDone, TakeJump
  );
endinterface

// File: rtl/trisc_fetch_sequencer.sv
// TRISC fetch sequencer: owns the PC, fetches instruction words, holds the IR
// for the control unit and advances/jumps/halts on instruction completion.
module trisc_fetch_sequencer #(
  parameter int              ADDR_W   = 4,
  parameter int              DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      SysClock,
  input  logic                      Reset_n,
  input  logic                      Start,
  trisc_fetch_sequencer_if.master   bus,
  output logic [ADDR_W-1:0]         PC,
  output logic                      Halted,
  output logic                      IllegalOp
);

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC, S_ADV} state_e;

  localparam logic [3:0] OP_HLT = 4'hA;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  always_ff @(posedge SysClock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_HALT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_HALT: begin
        if (Start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.MemAck) begin
          ir_d    = bus.MemData;
          // Opcodes above HLT are undefined; skip them without executing.
          state_d = (bus.MemData[DATA_W-1 -: 4] > OP_HLT) ? S_ADV : S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.InstrDone) begin
          if (ir_q[DATA_W-1 -: 4] == OP_HLT) begin
            state_d = S_HALT;
          end else begin
            pc_d    = bus.TakeJump ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_ADV: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  // All outputs decode from state/IR so nothing leaks combinationally from inputs.
  assign bus.MemReq     = (state_q == S_FETCH);
  assign bus.MemAddr    = pc_q;
  assign bus.Opcode     = ir_q[DATA_W-1 -: 4];
  assign bus.Operand    = ir_q[ADDR_W-1:0];
  assign bus.InstrValid = (state_q == S_EXEC);
  assign PC             = pc_q;
  assign Halted         = (state_q == S_HALT);
  assign IllegalOp      = (state_q == S_ADV);

endmodule

// File: tb/tb_trisc_fetch_sequencer.sv
// Directed bench for trisc_fetch_sequencer: memory responder model plus
// hand-computed expectations for fetch order, jumps, halts, skips and reset.
module tb_trisc_fetch_sequencer;

  logic       SysClock;
  logic       Reset_n;
  logic       Start;
  logic [3:0] PC;
  logic       Halted;
  logic       IllegalOp;

  trisc_fetch_sequencer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  trisc_fetch_sequencer #(.ADDR_W(4), .DATA_W(8), .RESET_PC(4'h0)) dut (
    .SysClock  (SysClock),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .bus       (bus),
    .PC        (PC),
    .Halted    (Halted),
    .IllegalOp (IllegalOp)
  );

  initial SysClock = 1'b0;
  always #5 SysClock = ~SysClock;

  logic [7:0] mem [16];
  logic       mem_en;
  logic [3:0] flog [$];
  int         ill_cnt;
  int         total;
  int         bad;

  // Memory answers in the same cycle it sees a request, unless stalled.
  always @(negedge SysClock) begin
    bus.MemAck = 1'b0;
    if (mem_en && bus.MemReq) begin
      bus.MemAck  = 1'b1;
      bus.MemData = mem[bus.MemAddr];
    end
  end

  always @(posedge SysClock)
    if (Reset_n && bus.MemReq && bus.MemAck) flog.push_back(bus.MemAddr);

  always @(negedge SysClock)
    if (IllegalOp) ill_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge SysClock);
    Reset_n       = 1'b0;
    Start         = 1'b0;
    bus.InstrDone = 1'b0;
    bus.TakeJump  = 1'b0;
    @(negedge SysClock);
    Reset_n = 1'b1;
    flog.delete();
    ill_cnt = 0;
  endtask

  task automatic start_pulse();
    @(negedge SysClock);
    Start = 1'b1;
    @(negedge SysClock);
    Start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !bus.InstrValid; i++) @(negedge SysClock);
    chk(tag, bus.InstrValid, 1'b1);
  endtask

  task automatic finish_instr(input logic tj);
    bus.InstrDone = 1'b1;
    bus.TakeJump  = tj;
    @(negedge SysClock);
    bus.InstrDone = 1'b0;
    bus.TakeJump  = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; ill_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem_en = 1'b1;
    Reset_n = 1'b0; Start = 1'b0;
    bus.InstrDone = 1'b0; bus.TakeJump = 1'b0;
    bus.MemAck = 1'b0; bus.MemData = 8'h00;
    #1;
    chk("rst_halted", Halted, 1'b1);
    chk("rst_memreq", bus.MemReq, 1'b0);
    chk("rst_valid", bus.InstrValid, 1'b0);
    chk("rst_illegal", IllegalOp, 1'b0);
    chk("rst_pc", PC, 4'h0);
    chk("rst_opcode", bus.Opcode, 4'h0);

    // Reset then start, first instruction 0x23
    mem[0] = 8'h23;
    do_reset();
    repeat (2) @(negedge SysClock);
    chk("idle_halted", Halted, 1'b1);
    chk("idle_memreq", bus.MemReq, 1'b0);
    start_pulse();
    chk("start_memreq", bus.MemReq, 1'b1);
    chk("start_addr", bus.MemAddr, 4'h0);
    chk("start_halted", Halted, 1'b0);
    wait_valid("first_valid");
    chk("first_opcode", bus.Opcode, 4'h2);
    chk("first_operand", bus.Operand, 4'h3);

    // Sequential run ending in HLT
    mem[0] = 8'h05; mem[1] = 8'h14; mem[2] = 8'hA0;
    do_reset();
    start_pulse();
    for (int k = 0; k < 3; k++) begin
      wait_valid("seq_valid");
      repeat (3) @(negedge SysClock);
      finish_instr(1'b0);
    end
    chk("seq_halted", Halted, 1'b1);
    chk("seq_pc", PC, 4'h2);
    chk("seq_nfetch", flog.size(), 3);
    for (int k = 0; k < 3 && k < flog.size(); k++) chk("seq_addr", flog[k], k);
    chk("seq_opcode_hlt", bus.Opcode, 4'hA);

    // Jump taken / not taken
    mem[0] = 8'h7C; mem[12] = 8'h50;
    do_reset();
    start_pulse();
    wait_valid("jmp_valid");
    finish_instr(1'b1);
    chk("jmp_taken_req", bus.MemReq, 1'b1);
    chk("jmp_taken_addr", bus.MemAddr, 4'hC);
    do_reset();
    start_pulse();
    wait_valid("jmp_valid2");
    finish_instr(1'b0);
    chk("jmp_not_addr", bus.MemAddr, 4'h1);

    // Illegal opcode at 0xF: skip and wrap
    mem[0] = 8'h7F; mem[15] = 8'hB0;
    do_reset();
    start_pulse();
    wait_valid("ill_pre_valid");
    finish_instr(1'b1);
    chk("ill_fetch_addr", bus.MemAddr, 4'hF);
    @(negedge SysClock);
    chk("ill_pulse", IllegalOp, 1'b1);
    chk("ill_novalid", bus.InstrValid, 1'b0);
    @(negedge SysClock);
    chk("ill_wrap_addr", bus.MemAddr, 4'h0);
    chk("ill_wrap_req", bus.MemReq, 1'b1);
    chk("ill_pulse_end", IllegalOp, 1'b0);
    chk("ill_count", ill_cnt, 1);

    // Legal instruction at 0xF wraps to 0
    mem[15] = 8'h20;
    do_reset();
    start_pulse();
    wait_valid("wrap_pre_valid");
    finish_instr(1'b1);
    wait_valid("wrap_valid");
    chk("wrap_pc", PC, 4'hF);
    finish_instr(1'b0);
    chk("wrap_addr", bus.MemAddr, 4'h0);

    // Stalled memory with stray InstrDone / Start
    mem[0] = 8'h35;
    mem_en = 1'b0;
    do_reset();
    start_pulse();
    for (int c = 0; c < 10; c++) begin
      bus.InstrDone = (c == 3);
      Start         = (c == 5);
      chk("stall_req", bus.MemReq, 1'b1);
      chk("stall_addr", bus.MemAddr, 4'h0);
      chk("stall_valid", bus.InstrValid, 1'b0);
      @(negedge SysClock);
    end
    bus.InstrDone = 1'b0; Start = 1'b0;
    chk("stall_pc", PC, 4'h0);
    mem_en = 1'b1;
    wait_valid("stall_valid_end");
    chk("stall_opcode", bus.Opcode, 4'h3);
    chk("stall_operand", bus.Operand, 4'h5);

    // Mid-operation reset while executing at PC=6
    mem[0] = 8'h76; mem[6] = 8'h2A;
    do_reset();
    start_pulse();
    wait_valid("mid_pre_valid");
    finish_instr(1'b1);
    wait_valid("mid_valid");
    chk("mid_pc6", PC, 4'h6);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.InstrValid, 1'b0);
    chk("mid_rst_halted", Halted, 1'b1);
    chk("mid_rst_pc", PC, 4'h0);
    @(negedge SysClock);
    Reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge SysClock);
      chk("post_rst_req", bus.MemReq, 1'b0);
    end
    start_pulse();
    chk("post_start_req", bus.MemReq, 1'b1);
    chk("post_start_addr", bus.MemAddr, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
